// File: rtl/regfile_reader.sv
// Read-side sequencer: scans register file addresses 0..NUM_REGS-1 through an async read
// port, captures each word and offers it downstream on a valid/ready stream.
module regfile_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StSend  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          rd_addr_d = '0;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        out_data_d  = rd_data;
        out_addr_d  = rd_addr_q;
        out_valid_d = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        // Captured word stays frozen until the consumer takes it.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (rd_addr_q == LastAddr) begin
            rd_addr_d = '0;
            state_d   = StDone;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            state_d   = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == StFetch) | (state_q == StSend);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: a 32-register instance driven by directed and random
// scans against a word-list model, plus a 4-register instance checked from a vector table.
module tb_regfile_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 32-register instance
  logic        start, out_ready, out_valid, busy, done;
  logic [4:0]  rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic [31:0] mem  [32];
  logic [31:0] gmem [32];

  // 4-register instance
  logic        s_start, s_ready, s_valid, s_busy, s_done;
  logic [4:0]  s_rd_addr, s_out_addr;
  logic [31:0] s_rd_data, s_out_data;

  int checks   = 0;
  int failures = 0;

  // Monitor state
  int          got_addr [$];
  logic [31:0] got_data [$];
  int          done_cnt = 0;
  int          over_cnt = 0;
  int          s_over   = 0;

  always #5 clk = ~clk;

  assign rd_data   = mem[rd_addr];
  assign s_rd_data = 32'h1EE7BA10 | {27'd0, s_rd_addr};

  regfile_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  regfile_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) u_small (
    .clk       (clk),
    .rst       (rst),
    .start     (s_start),
    .rd_addr   (s_rd_addr),
    .rd_data   (s_rd_data),
    .out_data  (s_out_data),
    .out_addr  (s_out_addr),
    .out_valid (s_valid),
    .out_ready (s_ready),
    .busy      (s_busy),
    .done      (s_done)
  );

  // Record every accepted word of the big instance.
  always @(posedge clk) begin
    if (rst && out_valid && out_ready) begin
      got_addr.push_back(int'(out_addr));
      got_data.push_back(out_data);
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rd_addr > 5'd31) over_cnt++;
    if (s_rd_addr > 5'd3) s_over++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full scan of the big instance; expected stream is gmem[0..31] in order.
  task automatic scan(input int bp_addr, input int bp_len, input int poke_addr, input bit rnd,
                      output int edges);
    int  held   = 0;
    bit  poked  = 0;
    bit  hold;
    int  base   = got_addr.size();
    int  dbase  = done_cnt;
    int  n;
    for (int i = 0; i < 32; i++) mem[i] = gmem[i];
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    edges = 1;
    start = 1'b0;
    while (!done && edges < 400) begin
      start = 1'b0;
      if (rnd) begin
        out_ready = ($urandom_range(0, 9) < 6);
        start     = ($urandom_range(0, 7) == 0);
      end else begin
        out_ready = 1'b1;
        if (out_valid && int'(out_addr) == bp_addr && held < bp_len) begin
          out_ready = 1'b0;
          held++;
        end
        if (out_valid && int'(out_addr) == poke_addr && !poked) begin
          start = 1'b1;
          poked = 1'b1;
        end
      end
      hold = out_valid && !out_ready;
      // Scribble over the register being held; the captured word must not follow it.
      if (hold) mem[out_addr] = $urandom;
      else if (out_valid) mem[out_addr] = gmem[out_addr];
      step();
      edges++;
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_addr", out_addr, got_addr.size() - base);
        chk("hold_data", out_data, gmem[got_addr.size() - base]);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", done, 1);
    chk("done_busy", busy, 0);
    step();
    chk("done_one_cycle", done, 0);
    step();
    chk("done_pulses", done_cnt - dbase, 1);
    n = got_addr.size() - base;
    chk("word_count", n, 32);
    for (int i = 0; i < n && i < 32; i++) begin
      chk("word_addr", got_addr[base + i], i);
      chk("word_data", got_data[base + i], gmem[i]);
    end
    chk("rd_addr_range", over_cnt, 0);
  endtask

  typedef struct {
    logic        st;
    logic        rdy;
    logic        v;
    logic        b;
    logic        d;
    logic [4:0]  ra;
    logic [4:0]  oa;
    logic [31:0] od;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int  edges;
    bit  found;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h1EE7BA10};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h1EE7BA10};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 32'h1EE7BA10};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 32'h1EE7BA11};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 5'd1, 32'h1EE7BA11};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd2, 32'h1EE7BA12};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd2, 32'h1EE7BA12};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 32'h1EE7BA13};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd3, 32'h1EE7BA13};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 32'h1EE7BA13};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 32'h1EE7BA13};

    for (int i = 0; i < 32; i++) begin
      gmem[i] = 32'hACE5F800 | i;
      mem[i]  = gmem[i];
    end

    // Reset with start and ready held high
    start = 1'b1; out_ready = 1'b1; s_start = 1'b1; s_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_busy", busy, 0);
    step(); step();
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_small_busy", s_busy, 0);
    start = 1'b0; s_start = 1'b0;
    rst = 1'b1;
    step(); step(); step();
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_done", done, 0);

    // Full scan, ready tied high
    scan(-1, 0, -1, 1'b0, edges);
    chk("scan_edges", edges, 65);

    // Backpressure on address 3
    scan(3, 5, -1, 1'b0, edges);
    chk("bp_edges", edges, 70);

    // Start pulse while busy at address 10
    scan(-1, 0, 10, 1'b0, edges);
    chk("poke_edges", edges, 65);

    // Reset mid-scan at address 5
    for (int i = 0; i < 32; i++) mem[i] = gmem[i];
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid && out_addr == 5'd5) found = 1'b1;
      else step();
    end
    chk("reach_addr5", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_out_addr", out_addr, 0);
    chk("midrst_out_data", out_data, 0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_idle", busy, 0);
    scan(-1, 0, -1, 1'b0, edges);
    chk("rescan_edges", edges, 65);

    // Random contents, random backpressure and stray starts
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) gmem[i] = $urandom;
      scan(-1, 0, -1, 1'b1, edges);
    end

    // Four-register instance: cycle table
    for (int i = 0; i < 13; i++) begin
      s_start = tbl[i].st;
      s_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].v);
      chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].b);
      chk($sformatf("tbl%0d_done", i), s_done, tbl[i].d);
      chk($sformatf("tbl%0d_rd_addr", i), s_rd_addr, tbl[i].ra);
      chk($sformatf("tbl%0d_out_addr", i), s_out_addr, tbl[i].oa);
      chk($sformatf("tbl%0d_out_data", i), s_out_data, tbl[i].od);
    end

    // Four-register instance: start to done-pulse edge count
    s_start = 1'b1;
    s_ready = 1'b1;
    step();
    edges = 1;
    s_start = 1'b0;
    while (!s_done && edges < 50) begin
      step();
      edges++;
    end
    chk("small_done_seen", s_done, 1);
    chk("small_edges", edges, 9);
    step();
    chk("small_done_once", s_done, 0);
    chk("small_rd_range", s_over, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
